// File: rtl/mux_pipeline_arbiter_pkg.sv
// Shared toolbox for the mux/arbiter blocks: index-width and one-hot encoding
// helpers, plus the arbitration decision type.
package mux_pipeline_arbiter_pkg;

  localparam int unsigned CNT_W = 8;

  typedef enum logic [1:0] {
    DEC_IDLE,
    DEC_HOLD,
    DEC_ROTATE
  } dec_e;

  // Index width for n items; never less than one bit.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 1;
    while ((64'd1 << r) < 64'(n)) r++;
    return r;
  endfunction

  function automatic int unsigned onehot_to_bin(input logic [63:0] oh);
    int unsigned b;
    b = 0;
    for (int unsigned i = 0; i < 64; i++) begin
      if (oh[i]) b = b | i;
    end
    return b;
  endfunction

endpackage

// File: rtl/mux_pipeline_arbiter_valid_delay_line.sv
// Fixed-depth valid/data shift register tracking selections in flight through
// the downstream pipelined mux.
module valid_delay_line #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data
);

  logic [DEPTH-1:0] vld_q;
  logic [WIDTH-1:0] dat_q [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) dat_q[i] <= '0;
    end else begin
      vld_q[0] <= in_valid;
      dat_q[0] <= in_data;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        vld_q[i] <= vld_q[i-1];
        dat_q[i] <= dat_q[i-1];
      end
    end
  end

  assign out_valid = vld_q[DEPTH-1];
  assign out_data  = dat_q[DEPTH-1];

endmodule

// File: rtl/mux_pipeline_arbiter.sv
// Round-robin arbiter with burst limiting that drives a pipelined mux select
// and tracks which requester owns each mux output LATENCY cycles later.
module mux_pipeline_arbiter
  import mux_pipeline_arbiter_pkg::*;
#(
  parameter int unsigned INPUT_COUNT = 4,
  parameter int unsigned LATENCY     = 2,
  parameter int unsigned MAX_BURST   = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          en,
  input  logic [INPUT_COUNT-1:0]        req,
  output logic [INPUT_COUNT-1:0]        gnt,
  output logic [clog2(INPUT_COUNT)-1:0] sel,
  output logic                          issue_valid,
  output logic                          out_valid,
  output logic [clog2(INPUT_COUNT)-1:0] out_tag
);

  localparam int unsigned IW = clog2(INPUT_COUNT);

  logic [IW-1:0]          ptr_q, ptr_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [INPUT_COUNT-1:0] gnt_d;
  logic [IW-1:0]          rr_idx, pick;
  logic                   rr_found;
  dec_e                   dec;

  // ptr_q holds (last granted + 1) mod INPUT_COUNT, so the search starts there.
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = '0;
    for (int unsigned i = 0; i < INPUT_COUNT; i++) begin
      int unsigned j;
      j = int'(ptr_q) + i;
      if (j >= INPUT_COUNT) j = j - INPUT_COUNT;
      if (!rr_found && req[IW'(j)]) begin
        rr_found = 1'b1;
        rr_idx   = IW'(j);
      end
    end
  end

  // The owner (sel) only counts as such once cnt_q is non-zero after reset.
  always_comb begin
    dec   = DEC_IDLE;
    pick  = sel;
    gnt_d = '0;
    cnt_d = cnt_q;
    ptr_d = ptr_q;
    if (en) begin
      if (cnt_q != '0 && req[sel] && cnt_q < CNT_W'(MAX_BURST)) begin
        dec   = DEC_HOLD;
        pick  = sel;
        cnt_d = cnt_q + CNT_W'(1);
      end else if (rr_found) begin
        dec   = DEC_ROTATE;
        pick  = rr_idx;
        cnt_d = CNT_W'(1);
      end
    end
    if (dec != DEC_IDLE) begin
      gnt_d[pick] = 1'b1;
      ptr_d       = (pick == IW'(INPUT_COUNT - 1)) ? '0 : pick + IW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt         <= '0;
      sel         <= '0;
      issue_valid <= 1'b0;
      ptr_q       <= '0;
      cnt_q       <= '0;
    end else begin
      gnt         <= gnt_d;
      issue_valid <= (dec != DEC_IDLE);
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      if (dec != DEC_IDLE) sel <= IW'(onehot_to_bin(64'(gnt_d)));
    end
  end

  valid_delay_line #(
    .DEPTH(LATENCY),
    .WIDTH(IW)
  ) u_delay (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (issue_valid),
    .in_data  (sel),
    .out_valid(out_valid),
    .out_data (out_tag)
  );

endmodule

// File: tb/tb_mux_pipeline_arbiter.sv
// Scoreboard bench for mux_pipeline_arbiter: directed scenarios followed by
// randomized req/en, checked against a behavioural round-robin model.
module tb_mux_pipeline_arbiter;

  localparam int N  = 4;
  localparam int L  = 2;
  localparam int MB = 2;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en;
  logic [N-1:0]  req;
  logic [N-1:0]  gnt;
  logic [IW-1:0] sel;
  logic          issue_valid;
  logic          out_valid;
  logic [IW-1:0] out_tag;

  always #5 clk = ~clk;

  mux_pipeline_arbiter #(
    .INPUT_COUNT(N),
    .LATENCY    (L),
    .MAX_BURST  (MB)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .req        (req),
    .gnt        (gnt),
    .sel        (sel),
    .issue_valid(issue_valid),
    .out_valid  (out_valid),
    .out_tag    (out_tag)
  );

  typedef struct {
    int tag;
    int due;
  } item_t;

  item_t sbq[$];
  int    cyc = 0;
  int    n_vec = 0;
  int    n_err = 0;

  // Reference state: last granted requester, consecutive-grant count, sel.
  int    m_last, m_cnt, m_sel;
  bit    m_has;
  int    wait_cnt[N];
  int    max_wait = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic bit bit_of(input logic [N-1:0] v, input int i);
    logic [N-1:0] t;
    t = v >> i;
    return t[0];
  endfunction

  task automatic model_reset();
    m_last = 0;
    m_cnt  = 0;
    m_sel  = 0;
    m_has  = 1'b0;
    for (int i = 0; i < N; i++) wait_cnt[i] = 0;
  endtask

  // One decision cycle: predict, clock, compare issue side, queue the output.
  task automatic step(input logic [N-1:0] r, input logic e);
    int pick;
    int start;
    req  = r;
    en   = e;
    pick = -1;
    if (e && r != '0) begin
      if (m_cnt > 0 && bit_of(r, m_last) && m_cnt < MB) begin
        pick  = m_last;
        m_cnt = m_cnt + 1;
      end else begin
        start = m_has ? (m_last + 1) % N : 0;
        for (int k = 0; k < N; k++)
          if (pick < 0 && bit_of(r, (start + k) % N)) pick = (start + k) % N;
        m_cnt = 1;
      end
    end
    if (pick >= 0) begin
      m_last = pick;
      m_sel  = pick;
      m_has  = 1'b1;
    end
    @(posedge clk);
    #1;
    chk("issue_valid", 32'(issue_valid), (pick >= 0) ? 32'd1 : 32'd0);
    chk("gnt", 32'(gnt), (pick >= 0) ? (32'd1 << pick) : 32'd0);
    chk("sel", 32'(sel), 32'(m_sel));
    if (pick >= 0) sbq.push_back('{tag: pick, due: cyc + L});
    for (int i = 0; i < N; i++) begin
      if (bit_of(gnt, i) || !bit_of(r, i)) wait_cnt[i] = 0;
      else if (gnt != '0) wait_cnt[i]++;
      if (wait_cnt[i] > max_wait) max_wait = wait_cnt[i];
    end
  endtask

  task automatic check_all_zero(input string tagname);
    chk({tagname, "_gnt"}, 32'(gnt), 32'd0);
    chk({tagname, "_sel"}, 32'(sel), 32'd0);
    chk({tagname, "_issue_valid"}, 32'(issue_valid), 32'd0);
    chk({tagname, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({tagname, "_out_tag"}, 32'(out_tag), 32'd0);
  endtask

  // Output monitor: an entry is due exactly LATENCY edges after its issue.
  initial begin
    forever begin
      bit exp_v;
      @(posedge clk);
      #2;
      while (sbq.size() > 0 && sbq[0].due < cyc) void'(sbq.pop_front());
      exp_v = (sbq.size() > 0 && sbq[0].due == cyc);
      chk("out_valid", 32'(out_valid), 32'(exp_v));
      if (exp_v) begin
        chk("out_tag", 32'(out_tag), 32'(sbq[0].tag));
        void'(sbq.pop_front());
      end
    end
  end

  initial begin
    #2_000_000;
    n_err++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $fatal(1, "timeout");
  end

  initial begin
    logic [N-1:0] rr;
    logic         ee;
    rst_n = 1'b0;
    req   = '0;
    en    = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    #3 rst_n = 1'b1;

    // alternating pair with burst limit
    repeat (8) step(4'b0101, 1'b1);
    repeat (3) step(4'b0000, 1'b1);
    // lone requester re-granted across burst expiry
    repeat (5) step(4'b1000, 1'b1);
    repeat (3) step(4'b0000, 1'b1);
    // owner drops request right after its first grant
    repeat (3) step(4'b1111, 1'b1);
    repeat (3) step(4'b1101, 1'b1);
    // enable removed mid-burst of requester 2
    step(4'b0101, 1'b1);
    repeat (3) step(4'b0101, 1'b0);
    repeat (3) step(4'b0101, 1'b1);
    repeat (2) step(4'b0000, 1'b1);

    // asynchronous reset with entries in flight
    repeat (2) step(4'b1111, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    sbq.delete();
    model_reset();
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    step(4'b1010, 1'b1);
    repeat (3) step(4'b1111, 1'b1);

    rr = '0;
    for (int t = 0; t < 3000; t++) begin
      if ($urandom_range(3) == 0) rr = N'($urandom);
      ee = ($urandom_range(7) != 0);
      step(rr, ee);
    end
    repeat (L + 2) step(4'b0000, 1'b1);

    chk("max_wait_bound", 32'(max_wait <= (N - 1) * MB), 32'd1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mux_pipeline_arbiter.md
MUX_PIPELINE_ARBITER -- requirements
Module: mux_pipeline_arbiter

Interface
REQ-001 SHALL have parameter INPUT_COUNT, default 4: number of requesters / mux inputs, range 2..64.
REQ-002 SHALL have parameter LATENCY, default 2: fixed latency of the downstream pipelined mux, in cycles, range 1..16.
REQ-003 SHALL have parameter MAX_BURST, default 4: maximum consecutive grants to one requester while others wait, range 1..255.
REQ-004 clk  input  1  sole clock, rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 en  input  1  high = new grants allowed; low = no new issue, in-flight entries still drain.
REQ-007 req  input  INPUT_COUNT  per-requester request, level-sensitive.
REQ-008 gnt  output  INPUT_COUNT  one-hot grant for the current issue cycle; all-zero when idle.
REQ-009 sel  output  clog2(INPUT_COUNT)  select driven to the downstream mux.
REQ-010 issue_valid  output  1  sel carries a granted selection this cycle.
REQ-011 out_valid  output  1  downstream mux output corresponds to a granted issue.
REQ-012 out_tag  output  clog2(INPUT_COUNT)  requester index owning the downstream mux output.

Function
REQ-013 gnt, sel and issue_valid SHALL be registered; a decision made from req at edge k SHALL appear on the outputs after edge k.
REQ-014 Arbitration SHALL be round-robin: search starts at index (last granted + 1) mod INPUT_COUNT and wraps; after reset the search starts at index 0.
REQ-015 The current owner SHALL keep the grant while its req stays high and its burst count is below MAX_BURST.
REQ-016 Burst count SHALL be 1 on a new grant, increment per consecutive grant to the same owner, and saturate at MAX_BURST.
REQ-017 At MAX_BURST, the owner SHALL lose priority and arbitration SHALL rotate; if no other req is high, the same owner SHALL be re-granted with the count restarted at 1.
REQ-018 If the owner drops req, a new grant SHALL be issued in the same decision (no bubble) when any other req is high.
REQ-019 With no req high, or with en low, gnt SHALL be 0, issue_valid SHALL be 0, sel SHALL hold its last value, and the pointer and burst count SHALL hold.
REQ-020 sel SHALL equal the binary index of the single gnt bit whenever issue_valid=1.
REQ-021 out_valid and out_tag SHALL equal issue_valid and sel delayed by exactly LATENCY cycles, independent of en and req.
REQ-022 Deasserting en mid-burst SHALL freeze the burst count, and re-asserting en SHALL resume the same owner if its req is still high.
REQ-023 The in-flight delay line SHALL hold at most LATENCY entries; there is no backpressure, and every issued selection SHALL emerge exactly once.

Reset
REQ-024 When rst_n is low, gnt=0, sel=0, issue_valid=0, out_valid=0, out_tag=0, pointer=0 and burst count=0, asynchronously.
REQ-025 Reset asserted mid-operation SHALL discard all in-flight entries; no out_valid SHALL appear for any issue made before the reset.
REQ-026 After rst_n deasserts, the first grant SHALL be on the first edge with en=1 and any req high.

Structure
REQ-027 The index-width function clog2 and a one-hot-to-binary encoder function SHALL live in the shared toolbox function include, reused by the mux blocks.
REQ-028 The LATENCY-deep valid/tag shift register SHALL be one sub-module, valid_delay_line, parameterised by depth and width, with asynchronous active-low reset.
REQ-029 The round-robin logic, pointer and burst counter SHALL reside in mux_pipeline_arbiter itself.

Verification
REQ-030 Bench configuration: INPUT_COUNT=4, LATENCY=2, MAX_BURST=2 unless stated otherwise.
REQ-031 req=0101 held, en=1 -> gnt sequence 0001,0001,0100,0100,0001,...; out_tag sequence 0,0,2,2,... starting 2 cycles after the first issue_valid.
REQ-032 Only req[3] held for 5 cycles -> gnt=1000 on every cycle, with no bubble when the burst expires; out_valid high for 5 consecutive cycles.
REQ-033 req=1111, req[1] dropped after its first grant -> next grant is 0100 in the very next cycle, with no idle cycle.
REQ-034 en pulled low for 3 cycles mid-burst of requester 2 -> issue_valid=0 for those 3 cycles and out_valid still drains the 2 in-flight entries; requester 2 gets exactly 1 more grant after en returns high.
REQ-035 rst_n asserted while 2 entries are in flight -> all outputs 0 immediately, no stale out_valid afterwards, and the first post-reset grant follows index-0-first priority.
REQ-036 INPUT_COUNT=10, LATENCY=4, random req/en for 10k cycles -> scoreboard: every issue appears as out_valid/out_tag exactly 4 cycles later; no requester waits more than 9*MAX_BURST grants.
